pulse_gen_multi_core: RTL and testbench

- Single-clock, multi-channel successor of the pulse generator core, with a byte-wide bus register interface.
- One shared period counter drives CHANNELS outputs. Each channel has its own delay and width inside a programmable period.
- The period repeats a programmable number of times, or forever.
- Sits behind a basil-style bus wrapper. Starts from a bus write or a synchronised EXT_START edge. Reports DONE.

---
 rtl/pulse_gen_multi_pkg.sv | 33 +++
 rtl/pulse_gen_multi_channel.sv | 38 +++
 rtl/pulse_gen_multi_core.sv | 212 +++++++++++++++++++++
 tb/tb_pulse_gen_multi_core.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_multi_pkg.sv
// Shared constants, register map and helpers for the multi-channel pulse generator.
package pulse_gen_multi_pkg;

    localparam logic [7:0] VERSION = 8'd2;

    // Byte addresses of the bus register map
    localparam int unsigned ADDR_RESET   = 0;
    localparam int unsigned ADDR_START   = 1;
    localparam int unsigned ADDR_EN      = 2;
    localparam int unsigned ADDR_PERIOD  = 3;
    localparam int unsigned ADDR_REPEAT  = 7;
    localparam int unsigned ADDR_MASK    = 11;
    localparam int unsigned ADDR_CH_BASE = 16;
    localparam int unsigned CH_STRIDE    = 8;
    localparam int unsigned CH_WIDTH_OFS = 4;

    typedef enum logic [0:0] {IDLE, RUN} state_e;

    // Replace byte idx of a 32-bit word
    function automatic logic [31:0] set_byte(input logic [31:0] old, input int unsigned idx,
                                             input logic [7:0] data);
        logic [31:0] r;
        r = old;
        r[idx*8 +: 8] = data;
        return r;
    endfunction

    // Extract byte idx of a 32-bit word
    function automatic logic [7:0] get_byte(input logic [31:0] val, input int unsigned idx);
        return val[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/pulse_gen_multi_channel.sv
// One output channel: compares the shared period counter against this channel's window.
module pulse_gen_channel #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 run_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] delay_i,
    input  logic [CNT_WIDTH-1:0] width_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    output logic                 pulse_o
);

    logic [CNT_WIDTH:0] win_end;
    logic               pulse_d;
    logic               pulse_q;

    // Window (delay, delay+width], clipped at the period end; the sum carries an extra bit
    always_comb begin
        win_end = {1'b0, delay_i} + {1'b0, width_i};
        pulse_d = run_i && en_i && (cnt_i > delay_i) && ({1'b0, cnt_i} <= win_end)
                  && (cnt_i <= period_i);
    end

    // Registered pulse output
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/pulse_gen_multi_core.sv
// Multi-channel pulse generator with byte-wide bus registers.
// Optional macro PULSE_GEN_MULTI_GATE_EN adds the EXT_GATE input that pauses a run.
module pulse_gen_multi_core
    import pulse_gen_multi_pkg::*;
#(
    parameter int unsigned ABUSWIDTH = 16,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_WR,
    input  logic                 BUS_RD,
    input  logic                 EXT_START,
`ifdef PULSE_GEN_MULTI_GATE_EN
    input  logic                 EXT_GATE,
`endif
    output logic [CHANNELS-1:0]  PULSE,
    output logic                 DONE
);

    logic [31:0] addr;
    logic        soft_rst, rst, start_wr, ext_edge, trig, gate, run_gated;

    logic                 conf_en_q, conf_en_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] repeat_q, repeat_d;
    logic [CHANNELS-1:0]  mask_q, mask_d;
    logic [CNT_WIDTH-1:0] delay_q [CHANNELS];
    logic [CNT_WIDTH-1:0] delay_d [CHANNELS];
    logic [CNT_WIDTH-1:0] width_q [CHANNELS];
    logic [CNT_WIDTH-1:0] width_d [CHANNELS];

    logic [2:0]           ext_sync_q;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] rpt_q, rpt_d;
    logic                 done_q, done_d;
    logic [7:0]           rdata, data_out_q;
    logic [CHANNELS-1:0]  pulse;

    assign addr     = 32'(BUS_ADD);
    assign soft_rst = BUS_WR && (addr == ADDR_RESET);
    assign rst      = BUS_RST || soft_rst;
    assign start_wr = BUS_WR && (addr == ADDR_START);
    // ext_sync_q[1] is the synchronised pin, ext_sync_q[2] its previous value
    assign ext_edge = ext_sync_q[1] && !ext_sync_q[2];
    assign trig     = start_wr || (ext_edge && conf_en_q);

`ifdef PULSE_GEN_MULTI_GATE_EN
    assign gate = EXT_GATE;
`else
    assign gate = 1'b1;
`endif

    // Configuration register writes
    always_comb begin
        conf_en_d = conf_en_q;
        period_d  = period_q;
        repeat_d  = repeat_q;
        mask_d    = mask_q;
        delay_d   = delay_q;
        width_d   = width_q;
        if (BUS_WR) begin
            if (addr == ADDR_EN) conf_en_d = BUS_DATA_IN[0];
            if (addr == ADDR_MASK) mask_d = BUS_DATA_IN[CHANNELS-1:0];
            for (int unsigned b = 0; b < 4; b++) begin
                if (addr == ADDR_PERIOD + b)
                    period_d = CNT_WIDTH'(set_byte(32'(period_q), b, BUS_DATA_IN));
                if (addr == ADDR_REPEAT + b)
                    repeat_d = CNT_WIDTH'(set_byte(32'(repeat_q), b, BUS_DATA_IN));
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (addr == ADDR_CH_BASE + CH_STRIDE * c + b)
                        delay_d[c] = CNT_WIDTH'(set_byte(32'(delay_q[c]), b, BUS_DATA_IN));
                    if (addr == ADDR_CH_BASE + CH_STRIDE * c + CH_WIDTH_OFS + b)
                        width_d[c] = CNT_WIDTH'(set_byte(32'(width_q[c]), b, BUS_DATA_IN));
                end
            end
        end
    end

    // Configuration registers and the EXT_START synchroniser
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            conf_en_q  <= 1'b0;
            period_q   <= '0;
            repeat_q   <= CNT_WIDTH'(1);
            mask_q     <= '1;
            ext_sync_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                delay_q[c] <= '0;
                width_q[c] <= '0;
            end
        end else begin
            conf_en_q  <= conf_en_d;
            period_q   <= period_d;
            repeat_q   <= repeat_d;
            mask_q     <= mask_d;
            ext_sync_q <= {ext_sync_q[1:0], EXT_START};
            delay_q    <= delay_d;
            width_q    <= width_d;
        end
    end

    // Read mux
    always_comb begin
        rdata = '0;
        if (addr == ADDR_RESET) rdata = VERSION;
        if (addr == ADDR_START) rdata = {7'b0, done_q};
        if (addr == ADDR_EN) rdata = {7'b0, conf_en_q};
        if (addr == ADDR_MASK) rdata = 8'(mask_q);
        for (int unsigned b = 0; b < 4; b++) begin
            if (addr == ADDR_PERIOD + b) rdata = get_byte(32'(period_q), b);
            if (addr == ADDR_REPEAT + b) rdata = get_byte(32'(repeat_q), b);
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (addr == ADDR_CH_BASE + CH_STRIDE * c + b)
                    rdata = get_byte(32'(delay_q[c]), b);
                if (addr == ADDR_CH_BASE + CH_STRIDE * c + CH_WIDTH_OFS + b)
                    rdata = get_byte(32'(width_q[c]), b);
            end
        end
    end

    // Read data register, holds while BUS_RD is low
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            data_out_q <= '0;
        end else if (BUS_RD) begin
            data_out_q <= rdata;
        end
    end

    // Sequencer next state; a trigger in RUN restarts the sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        unique case (state_q)
            IDLE: begin
                if (trig && (period_q != '0)) begin
                    state_d = RUN;
                    cnt_d   = CNT_WIDTH'(1);
                    rpt_d   = repeat_q;
                end
            end
            RUN: begin
                if (trig) begin
                    cnt_d = CNT_WIDTH'(1);
                    rpt_d = repeat_q;
                end else if (gate) begin
                    // >= so a period shortened mid-run still terminates the period
                    if (cnt_q >= period_q) begin
                        if (repeat_q == '0) begin
                            cnt_d = CNT_WIDTH'(1);
                        end else if (rpt_q > CNT_WIDTH'(1)) begin
                            rpt_d = rpt_q - CNT_WIDTH'(1);
                            cnt_d = CNT_WIDTH'(1);
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == IDLE);
    end

    // Sequencer state
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rpt_q   <= '0;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            done_q  <= done_d;
        end
    end

    assign run_gated = (state_q == RUN) && gate;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pulse_gen_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk_i   (BUS_CLK),
            .rst_i   (rst),
            .cnt_i   (cnt_q),
            .run_i   (run_gated),
            .en_i    (mask_q[c]),
            .delay_i (delay_q[c]),
            .width_i (width_q[c]),
            .period_i(period_q),
            .pulse_o (pulse[c])
        );
    end

    assign PULSE        = pulse;
    assign DONE         = done_q;
    assign BUS_DATA_OUT = data_out_q;

endmodule

// File: tb/tb_pulse_gen_multi_core.sv
// Scoreboard bench for pulse_gen_multi_core: stimulus queues expectations, a monitor checks them.
module tb_pulse_gen_multi_core;

    logic        clk = 1'b0;
    logic        BUS_RST = 1'b0;
    logic [15:0] BUS_ADD = '0;
    logic [7:0]  BUS_DATA_IN = '0;
    logic [7:0]  BUS_DATA_OUT;
    logic        BUS_WR = 1'b0;
    logic        BUS_RD = 1'b0;
    logic        EXT_START = 1'b0;
    logic        EXT_GATE = 1'b1;
    logic [3:0]  PULSE;
    logic        DONE;

    always #5 clk = ~clk;

    pulse_gen_multi_core #(
        .ABUSWIDTH(16),
        .CHANNELS (4),
        .CNT_WIDTH(32)
    ) dut (
        .BUS_CLK     (clk),
        .BUS_RST     (BUS_RST),
        .BUS_ADD     (BUS_ADD),
        .BUS_DATA_IN (BUS_DATA_IN),
        .BUS_DATA_OUT(BUS_DATA_OUT),
        .BUS_WR      (BUS_WR),
        .BUS_RD      (BUS_RD),
        .EXT_START   (EXT_START),
`ifdef PULSE_GEN_MULTI_GATE_EN
        .EXT_GATE    (EXT_GATE),
`endif
        .PULSE       (PULSE),
        .DONE        (DONE)
    );

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic       d;
        string      nm;
    } tr_t;

    typedef struct {
        logic [7:0] v;
        string      nm;
    } rd_t;

    tr_t  trq[$];
    rd_t  rdq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic rd_v = 1'b0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_v <= BUS_RD;
    end

    // Monitor: read data when valid, {PULSE,DONE} on the cycles the scoreboard names
    always @(negedge clk) begin : mon
        rd_t re;
        tr_t te;
        if (rd_v) begin
            n_chk++;
            if (rdq.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected got=%02h", BUS_DATA_OUT);
            end else begin
                re = rdq.pop_front();
                if (BUS_DATA_OUT !== re.v) begin
                    n_fail++;
                    $display("FAIL %s got=%02h exp=%02h", re.nm, BUS_DATA_OUT, re.v);
                end
            end
        end
        while (trq.size() > 0 && trq[0].cyc <= cyc) begin
            te = trq.pop_front();
            n_chk++;
            if (te.cyc != cyc || {PULSE, DONE} !== {te.p, te.d}) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got pulse=%b done=%b exp pulse=%b done=%b",
                         te.nm, te.cyc, PULSE, DONE, te.p, te.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int unsigned a, input logic [7:0] d);
        BUS_ADD     = 16'(a);
        BUS_DATA_IN = d;
        BUS_WR      = 1'b1;
        tick();
        BUS_WR = 1'b0;
    endtask

    task automatic wr32(input int unsigned a, input logic [31:0] v);
        for (int b = 0; b < 4; b++) wr(a + 32'(b), v[b*8 +: 8]);
    endtask

    task automatic rd(input int unsigned a, input logic [7:0] e, input string nm);
        rd_t r;
        r.v  = e;
        r.nm = nm;
        rdq.push_back(r);
        BUS_ADD = 16'(a);
        BUS_RD  = 1'b1;
        tick();
        BUS_RD = 1'b0;
    endtask

    task automatic exp_tr(input int c, input logic [3:0] p, input logic d, input string nm);
        tr_t t;
        t.cyc = c;
        t.p   = p;
        t.d   = d;
        t.nm  = nm;
        trq.push_back(t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t;
        int ck, cp;
        logic p0, p1, d;

        // Reset values
        tick();
        BUS_RST = 1'b1;
        tick();
        BUS_RST = 1'b0;
        exp_tr(cyc, 4'b0000, 1'b1, "reset_state");
        rd(0, 8'h02, "version");
        rd(1, 8'h01, "done_rst");
        rd(7, 8'h01, "repeat_rst");
        rd(11, 8'h0f, "mask_rst");
        rd(3, 8'h00, "period_rst");
        rd(50, 8'h00, "unused_addr");

        // Register readback, unused bits, soft reset of registers
        wr32(3, 32'h12345678);
        rd(4, 8'h56, "period_byte1");
        rd(6, 8'h12, "period_byte3");
        wr(2, 8'hff);
        rd(2, 8'h01, "conf_en_bits");
        wr(11, 8'hff);
        rd(11, 8'h0f, "mask_bits");
        wr(0, 8'h00);
        rd(3, 8'h00, "period_soft_rst");
        rd(2, 8'h00, "conf_en_soft_rst");

        // Single period, two channels
        wr32(3, 10);
        wr32(16, 2);
        wr32(20, 3);
        wr32(24, 0);
        wr32(28, 10);
        t = cyc;
        for (int k = 1; k <= 13; k++) begin
            p0 = (k >= 4 && k <= 6);
            p1 = (k >= 2 && k <= 11);
            d  = !(k <= 10);
            exp_tr(t + k, {2'b00, p1, p0}, d, "single_period");
        end
        wr(1, 8'h00);
        idle(14);

        // Repeat 3 with window truncated at the period end
        wr(0, 8'h00);
        wr32(3, 5);
        wr32(7, 3);
        wr32(16, 3);
        wr32(20, 9);
        t = cyc;
        for (int k = 1; k <= 17; k++) begin
            ck = (k <= 15) ? ((k - 1) % 5) + 1 : 0;
            cp = (k >= 2 && k - 1 <= 15) ? ((k - 2) % 5) + 1 : 0;
            p0 = (cp >= 4);
            d  = (k > 15);
            exp_tr(t + k, {3'b000, p0}, d, "repeat_trunc");
            if (ck < 0) $display("unreachable");
        end
        wr(1, 8'h00);
        idle(18);

        // Infinite repeat
        wr32(7, 0);
        wr(1, 8'h00);
        idle(1000);
        rd(1, 8'h00, "repeat0_running");
        wr(0, 8'h00);
        rd(1, 8'h01, "repeat0_soft_stop");

        // EXT_START ignored while CONF_EN=0
        wr32(3, 10);
        EXT_START = 1'b1;
        idle(3);
        EXT_START = 1'b0;
        idle(3);
        rd(1, 8'h01, "ext_disabled");

        // EXT_START with latency 3, then a restart that reloads the repeat count
        wr(2, 8'h01);
        wr32(3, 4);
        wr32(7, 2);
        wr32(20, 1);
        idle(4);
        t = cyc;
        for (int k = 1; k <= 18; k++) begin
            p0 = (k == 4 || k == 8 || k == 10 || k == 14);
            d  = (k <= 2 || k >= 17);
            exp_tr(t + k, {3'b000, p0}, d, "ext_restart");
        end
        EXT_START = 1'b1;
        idle(3);
        EXT_START = 1'b0;
        idle(3);
        EXT_START = 1'b1;
        idle(3);
        EXT_START = 1'b0;
        idle(12);

        // PERIOD=0 ignores START
        wr(0, 8'h00);
        t = cyc;
        for (int k = 1; k <= 5; k++) exp_tr(t + k, 4'b0000, 1'b1, "period_zero");
        wr(1, 8'h00);
        idle(5);

        // Channel mask 0x2
        wr32(3, 6);
        wr32(20, 6);
        wr32(28, 6);
        wr(11, 8'h02);
        t = cyc;
        for (int k = 1; k <= 8; k++) begin
            p1 = (k >= 2 && k <= 7);
            d  = !(k <= 6);
            exp_tr(t + k, {2'b00, p1, 1'b0}, d, "mask_ch1");
        end
        wr(1, 8'h00);
        idle(8);

        // Soft reset mid-run
        wr(0, 8'h00);
        wr32(3, 10);
        wr32(20, 10);
        t = cyc;
        exp_tr(t + 1, 4'b0000, 1'b0, "softrst_run");
        for (int k = 2; k <= 4; k++) exp_tr(t + k, 4'b0001, 1'b0, "softrst_run");
        exp_tr(t + 5, 4'b0000, 1'b1, "softrst_stop");
        exp_tr(t + 6, 4'b0000, 1'b1, "softrst_stop");
        wr(1, 8'h00);
        idle(3);
        wr(0, 8'h00);
        idle(2);
        rd(3, 8'h00, "period_after_softrst");

        // START together with BUS_RST stays idle
        wr32(3, 10);
        t = cyc;
        for (int k = 1; k <= 4; k++) exp_tr(t + k, 4'b0000, 1'b1, "start_with_rst");
        BUS_ADD = 16'd1;
        BUS_WR  = 1'b1;
        BUS_RST = 1'b1;
        tick();
        BUS_WR  = 1'b0;
        BUS_RST = 1'b0;
        idle(4);
        rd(3, 8'h00, "period_after_rst");

`ifdef PULSE_GEN_MULTI_GATE_EN
        // Gate low for 4 cycles mid-run extends the run by 4
        wr32(3, 10);
        wr32(20, 10);
        t = cyc;
        for (int k = 1; k <= 16; k++) begin
            p0 = (k >= 2 && k <= 4) || (k >= 9 && k <= 15);
            d  = !(k <= 14);
            exp_tr(t + k, {3'b000, p0}, d, "gate");
        end
        wr(1, 8'h00);
        idle(3);
        EXT_GATE = 1'b0;
        idle(4);
        EXT_GATE = 1'b1;
        idle(10);
`endif

        idle(3);
        if (trq.size() != 0 || rdq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL leftover trace=%0d reads=%0d exp 0", trq.size(), rdq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
